// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the execute stage: command encoding, mul/div FSM states
// and small decode helpers.
package exe_muldiv_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [4:0] {
        CMD_ADD   = 5'd0,
        CMD_SUB   = 5'd1,
        CMD_AND   = 5'd2,
        CMD_OR    = 5'd3,
        CMD_XOR   = 5'd4,
        CMD_NOR   = 5'd5,
        CMD_SLT   = 5'd6,
        CMD_SLTU  = 5'd7,
        CMD_SLL   = 5'd8,
        CMD_SRL   = 5'd9,
        CMD_SRA   = 5'd10,
        CMD_LUI   = 5'd11,
        CMD_MULT  = 5'd12,
        CMD_MULTU = 5'd13,
        CMD_DIV   = 5'd14,
        CMD_DIVU  = 5'd15,
        CMD_MFHI  = 5'd16,
        CMD_MFLO  = 5'd17,
        CMD_MTHI  = 5'd18,
        CMD_MTLO  = 5'd19
    } exe_cmd_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_muldiv(input exe_cmd_e c);
        return (c == CMD_MULT) || (c == CMD_MULTU) || (c == CMD_DIV) || (c == CMD_DIVU);
    endfunction

    function automatic logic is_div(input exe_cmd_e c);
        return (c == CMD_DIV) || (c == CMD_DIVU);
    endfunction

    function automatic logic is_signed_md(input exe_cmd_e c);
        return (c == CMD_MULT) || (c == CMD_DIV);
    endfunction

endpackage

// File: rtl/exe_muldiv_stage_muldiv_unit.sv
// Iterative HI/LO unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction on the final write.
module muldiv_unit
    import exe_muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_req,
    input  exe_cmd_e          i_cmd,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_hi_we,
    input  logic              i_lo_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_active,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_rem, r_quo;
    logic                r_neg_res, r_neg_rem, r_dz;
    logic [DATA_W-1:0]   r_hi, r_lo;

    logic                w_issue, w_last, w_signed;
    logic                w_a_neg, w_b_neg;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_prod_nxt, w_prod_fix;
    logic [DATA_W:0]     w_div_sh, w_div_diff;
    logic                w_qbit;
    logic [DATA_W-1:0]   w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;

    assign w_issue  = (r_state == MD_IDLE) && i_req && !i_flush;
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_signed = is_signed_md(i_cmd);
    assign w_a_neg  = w_signed && i_a[DATA_W-1];
    assign w_b_neg  = w_signed && i_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? (DATA_W'(0) - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (DATA_W'(0) - i_b) : i_b;

    // Multiply: r_prod = {accumulator, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_prod_nxt = {w_mul_sum, r_prod[DATA_W-1:1]};
    assign w_prod_fix = r_neg_res ? ((2*DATA_W)'(0) - w_prod_nxt) : w_prod_nxt;

    // Divide: dividend bits shift out of r_quo while quotient bits shift in
    assign w_div_sh   = {r_rem, r_quo[DATA_W-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_qbit     = !w_div_diff[DATA_W];
    assign w_rem_nxt  = w_qbit ? w_div_diff[DATA_W-1:0] : w_div_sh[DATA_W-1:0];
    assign w_quo_nxt  = {r_quo[DATA_W-2:0], w_qbit};
    // With a zero divisor the remainder ends up as |dividend|, so the sign fix restores the dividend
    assign w_rem_fix  = r_neg_rem ? (DATA_W'(0) - w_rem_nxt) : w_rem_nxt;
    assign w_quo_fix  = r_dz ? '1 : (r_neg_res ? (DATA_W'(0) - w_quo_nxt) : w_quo_nxt);

    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (i_req) w_state_nxt = is_div(i_cmd) ? MD_DIV : MD_MUL;
                MD_MUL,
                MD_DIV:  if (w_last) w_state_nxt = MD_DONE;
                MD_DONE: w_state_nxt = MD_IDLE;
                default: w_state_nxt = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy   = (r_state != MD_IDLE);
        o_active = (r_state == MD_MUL) || (r_state == MD_DIV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_prod    <= '0;
            r_opb     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
            if (w_issue) begin
                r_cnt     <= '0;
                r_prod    <= {{DATA_W{1'b0}}, w_a_mag};
                r_opb     <= w_b_mag;
                r_rem     <= '0;
                r_quo     <= w_a_mag;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_dz      <= (i_b == '0);
            end else if (!i_flush && r_state == MD_MUL) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= w_prod_nxt;
                if (w_last) begin
                    r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                    r_lo <= w_prod_fix[DATA_W-1:0];
                end
            end else if (!i_flush && r_state == MD_DIV) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                if (w_last) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/exe_muldiv_stage.sv
// Execute stage: single-cycle ALU result mux plus the pipeline stall driven by
// the iterative mul/div unit.
module exe_muldiv_stage
    import exe_muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    input  logic [4:0]        i_exe_cmd,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    input  logic [DATA_W-1:0] i_sign_ex,
    input  logic              i_use_imm,
    output logic [DATA_W-1:0] o_alu_result,
    output logic              o_stall,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi_q,
    output logic [DATA_W-1:0] o_lo_q
);

    localparam int SH_W = $clog2(DATA_W);

    exe_cmd_e          w_cmd;
    logic [DATA_W-1:0] w_opb;
    logic [SH_W-1:0]   w_shamt;
    logic              w_md_req, w_md_active, w_hi_we, w_lo_we;
    logic [DATA_W-1:0] w_alu;

    assign w_cmd    = exe_cmd_e'(i_exe_cmd);
    assign w_opb    = i_use_imm ? i_sign_ex : i_src2;
    assign w_shamt  = i_src1[SH_W-1:0];
    assign w_md_req = i_in_valid && is_muldiv(w_cmd);

    // Issue cycle stalls combinationally; DONE releases so the instruction can leave ID/EXE
    assign o_stall = !i_flush && ((!o_busy && w_md_req) || w_md_active);
    assign w_hi_we = i_in_valid && !o_stall && (w_cmd == CMD_MTHI);
    assign w_lo_we = i_in_valid && !o_stall && (w_cmd == CMD_MTLO);

    muldiv_unit #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (i_flush),
        .i_req    (w_md_req),
        .i_cmd    (w_cmd),
        .i_a      (i_src1),
        .i_b      (w_opb),
        .i_hi_we  (w_hi_we),
        .i_lo_we  (w_lo_we),
        .i_wdata  (i_src1),
        .o_busy   (o_busy),
        .o_active (w_md_active),
        .o_hi     (o_hi_q),
        .o_lo     (o_lo_q)
    );

    always_comb begin
        w_alu = '0;
        case (w_cmd)
            CMD_ADD:  w_alu = i_src1 + w_opb;
            CMD_SUB:  w_alu = i_src1 - w_opb;
            CMD_AND:  w_alu = i_src1 & w_opb;
            CMD_OR:   w_alu = i_src1 | w_opb;
            CMD_XOR:  w_alu = i_src1 ^ w_opb;
            CMD_NOR:  w_alu = ~(i_src1 | w_opb);
            CMD_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(i_src1) < $signed(w_opb))};
            CMD_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (i_src1 < w_opb)};
            CMD_SLL:  w_alu = w_opb << w_shamt;
            CMD_SRL:  w_alu = w_opb >> w_shamt;
            CMD_SRA:  w_alu = DATA_W'($signed(w_opb) >>> w_shamt);
            CMD_LUI:  w_alu = w_opb << 16;
            CMD_MFHI: w_alu = o_hi_q;
            CMD_MFLO: w_alu = o_lo_q;
            default:  w_alu = '0;
        endcase
    end

    assign o_alu_result = i_in_valid ? w_alu : '0;

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Directed bench for exe_muldiv_stage: an arithmetic reference model checked every
// cycle, plus literal expectations on the key vectors.
module tb_exe_muldiv_stage;
    import exe_muldiv_pkg::*;

    localparam int W  = 32;
    localparam int MD = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_flush = 1'b0, i_in_valid = 1'b0, i_use_imm = 1'b0;
    logic [4:0]    i_exe_cmd = 5'd0;
    logic [W-1:0]  i_src1 = '0, i_src2 = '0, i_sign_ex = '0;
    logic [W-1:0]  o_alu_result, o_hi_q, o_lo_q;
    logic          o_stall, o_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: cycles since issue (0 = idle), HI/LO and the pending result
    bit            m_init = 0;
    int            m_phase = 0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic [63:0]   m_pend = '0;

    exe_muldiv_stage #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_in_valid(i_in_valid),
        .i_exe_cmd(i_exe_cmd), .i_src1(i_src1), .i_src2(i_src2),
        .i_sign_ex(i_sign_ex), .i_use_imm(i_use_imm),
        .o_alu_result(o_alu_result), .o_stall(o_stall), .o_busy(o_busy),
        .o_hi_q(o_hi_q), .o_lo_q(o_lo_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] opb();
        return i_use_imm ? i_sign_ex : i_src2;
    endfunction

    function automatic bit md_req();
        return i_in_valid && (i_exe_cmd >= 5'd12) && (i_exe_cmd <= 5'd15);
    endfunction

    function automatic bit e_stall();
        return !i_flush && ((m_phase == 0 && md_req()) || (m_phase >= 1 && m_phase <= MD));
    endfunction

    function automatic logic [W-1:0] e_alu();
        logic [W-1:0] a, b;
        int sh;
        a = i_src1; b = opb(); sh = int'(a[4:0]);
        if (!i_in_valid) return '0;
        case (i_exe_cmd)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << sh;
            5'd9:  return b >> sh;
            5'd10: return 32'($signed(b) >>> sh);
            5'd11: return {b[15:0], 16'h0000};
            5'd16: return m_hi;
            5'd17: return m_lo;
            default: return '0;
        endcase
    endfunction

    // Returns {HI, LO} from plain signed/unsigned arithmetic
    function automatic logic [63:0] md_ref(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        int ia, ib, q, r;
        logic [63:0] p;
        p = '0;
        case (c)
            5'd12: begin sa = longint'($signed(a)); sb = longint'($signed(b)); p = 64'(sa * sb); end
            5'd13: p = {32'd0, a} * {32'd0, b};
            5'd14: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else begin ia = a; ib = b; q = ia / ib; r = ia % ib; p = {r, q}; end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Model update at the active edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_init = 1; m_phase = 0; m_hi = '0; m_lo = '0;
            end else if (m_init) begin
                if (i_in_valid && !e_stall() && i_exe_cmd == 5'd18) m_hi = i_src1;
                if (i_in_valid && !e_stall() && i_exe_cmd == 5'd19) m_lo = i_src1;
                if (i_flush) m_phase = 0;
                else if (m_phase == 0) begin
                    if (md_req()) begin m_phase = 1; m_pend = md_ref(i_exe_cmd, i_src1, opb()); end
                end else if (m_phase < MD) m_phase++;
                else if (m_phase == MD) begin m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; m_phase++; end
                else m_phase = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("model_alu",   o_alu_result, e_alu());
                chk("model_stall", {31'd0, o_stall}, {31'd0, e_stall()});
                chk("model_busy",  {31'd0, o_busy}, {31'd0, (m_phase != 0)});
                chk("model_hi",    o_hi_q, m_hi);
                chk("model_lo",    o_lo_q, m_lo);
            end
        end
    end

    task automatic issue(input logic v, input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm = '0, input logic ui = 1'b0, input logic fl = 1'b0);
        @(posedge clk); #1;
        i_in_valid = v; i_exe_cmd = c; i_src1 = a; i_src2 = b;
        i_sign_ex = imm; i_use_imm = ui; i_flush = fl;
    endtask

    // Issues a mul/div, holds it while stalled, and returns at the DONE cycle
    task automatic run_md(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        issue(1'b1, c, a, b);
        n = 0;
        @(negedge clk);
        while (o_stall === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("stall_len", 32'(n), 32'd33);
        chk("done_busy", {31'd0, o_busy}, 32'd1);
    endtask

    typedef struct { logic [4:0] c; logic [W-1:0] a, b, imm; logic ui; } vec_t;
    vec_t alu_vecs[10];

    initial begin
        alu_vecs[0] = '{5'd0,  32'd10,        32'd0,        32'hFFFFFFFC, 1'b1};
        alu_vecs[1] = '{5'd2,  32'hF0F0F0F0,  32'h0FF00FF0, 32'd0, 1'b0};
        alu_vecs[2] = '{5'd3,  32'h00FF0000,  32'h000000FF, 32'd0, 1'b0};
        alu_vecs[3] = '{5'd4,  32'hAAAA5555,  32'hFFFF0000, 32'd0, 1'b0};
        alu_vecs[4] = '{5'd5,  32'h0000000F,  32'hF0000000, 32'd0, 1'b0};
        alu_vecs[5] = '{5'd8,  32'd4,         32'h0000000F, 32'd0, 1'b0};
        alu_vecs[6] = '{5'd9,  32'd36,        32'h80000000, 32'd0, 1'b0};
        alu_vecs[7] = '{5'd6,  32'hFFFFFFFF,  32'd1,        32'd0, 1'b0};
        alu_vecs[8] = '{5'd7,  32'd1,         32'hFFFFFFFF, 32'd0, 1'b0};
        alu_vecs[9] = '{5'd0,  32'd1,         32'd2,        32'd0, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_hi", o_hi_q, 32'd0);
        chk("rst_lo", o_lo_q, 32'd0);

        issue(1, 5'd1, 32'd5, 32'd7);          @(negedge clk); chk("sub", o_alu_result, 32'hFFFFFFFE);
        issue(1, 5'd6, 32'd5, 32'd7);          @(negedge clk); chk("slt", o_alu_result, 32'd1);
        issue(1, 5'd7, 32'hFFFFFFFF, 32'd1);   @(negedge clk); chk("sltu", o_alu_result, 32'd0);
        issue(1, 5'd10, 32'd4, 32'h80000000);  @(negedge clk); chk("sra", o_alu_result, 32'hF8000000);
        issue(1, 5'd11, 32'd0, 32'd0, 32'h00001234, 1'b1); @(negedge clk); chk("lui", o_alu_result, 32'h12340000);
        for (int i = 0; i < 9; i++) issue(1, alu_vecs[i].c, alu_vecs[i].a, alu_vecs[i].b, alu_vecs[i].imm, alu_vecs[i].ui);
        issue(0, alu_vecs[9].c, alu_vecs[9].a, alu_vecs[9].b); @(negedge clk); chk("bubble", o_alu_result, 32'd0);

        run_md(5'd12, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", o_hi_q, 32'hFFFFFFFF);
        chk("mult_lo", o_lo_q, 32'hFFFFFFFA);
        issue(1, 5'd17, 32'd0, 32'd0); @(negedge clk); chk("mflo", o_alu_result, 32'hFFFFFFFA);

        run_md(5'd14, 32'hFFFFFFF9, 32'd2);
        chk("div_hi", o_hi_q, 32'hFFFFFFFF);
        chk("div_lo", o_lo_q, 32'hFFFFFFFD);
        run_md(5'd15, 32'd7, 32'd0);
        chk("divz_hi", o_hi_q, 32'd7);
        chk("divz_lo", o_lo_q, 32'hFFFFFFFF);
        run_md(5'd14, 32'h80000000, 32'hFFFFFFFF);
        chk("divov_hi", o_hi_q, 32'd0);
        chk("divov_lo", o_lo_q, 32'h80000000);

        issue(1, 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1 i_flush = 1'b1;
        @(negedge clk); chk("flush_stall", {31'd0, o_stall}, 32'd0);
        issue(0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        chk("flush_hi", o_hi_q, 32'd0);
        chk("flush_lo", o_lo_q, 32'h80000000);
        run_md(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_hi", o_hi_q, 32'hFFFFFFFE);
        chk("multu_lo", o_lo_q, 32'd1);

        issue(1, 5'd12, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        @(negedge clk); chk("flush_issue_stall", {31'd0, o_stall}, 32'd0);
        issue(0, 5'd0, 32'd0, 32'd0);
        @(negedge clk); chk("flush_issue_busy", {31'd0, o_busy}, 32'd0);

        issue(1, 5'd14, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; i_in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy",  {31'd0, o_busy}, 32'd0);
        chk("rstmid_stall", {31'd0, o_stall}, 32'd0);
        chk("rstmid_hi", o_hi_q, 32'd0);
        chk("rstmid_lo", o_lo_q, 32'd0);

        issue(1, 5'd18, 32'h00001234, 32'd0);
        issue(1, 5'd19, 32'h0000ABCD, 32'd0);
        @(negedge clk); chk("mthi", o_hi_q, 32'h00001234);
        issue(1, 5'd16, 32'd0, 32'd0);
        @(negedge clk);
        chk("mtlo", o_lo_q, 32'h0000ABCD);
        chk("mfhi", o_alu_result, 32'h00001234);

        issue(0, 5'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
